// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one combinational instruction-memory port between
// the I-cache refill burst engine and the CPU data-side read path. Refills
// stream up to BLOCK_SIZE words; data reads take a single word. Ties are
// broken round-robin so neither requester can starve the other.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_mem_req,
  input  logic [ADDR_WIDTH-1:0] cache_mem_addr,
  input  logic [3:0]            cache_mem_burst_len,
  output logic                  cache_mem_ready,
  output logic [DATA_WIDTH-1:0] cache_mem_data,
  output logic                  cache_mem_valid,
  output logic                  cache_mem_last,
  input  logic                  dport_req,
  input  logic [ADDR_WIDTH-1:0] dport_addr,
  output logic [DATA_WIDTH-1:0] dport_rdata,
  output logic                  dport_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  grant_cache,
  output logic                  grant_data
);

  localparam int BEAT_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int MAX_LEN = BLOCK_SIZE - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  logic [1:0]            state;
  logic [BEAT_W-1:0]     beat;
  logic [BEAT_W-1:0]     len;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic                  last_grant_cache;  // 1: cache won last, 0: data won last

  logic                  eff_cache;
  logic                  eff_data;
  logic                  pick_cache;
  logic [BEAT_W-1:0]     clamped_len;

  // Requests are masked in the cycle their own handshake pulse is high, so a
  // requester that has not yet dropped its request is not served twice.
  assign eff_cache  = cache_mem_req && !cache_mem_ready;
  assign eff_data   = dport_req && !dport_ack;
  assign pick_cache = eff_cache && (!eff_data || !last_grant_cache);

  assign grant_cache = (state == BURST);
  assign grant_data  = (state == DATA);

  // Clamp the requested burst length to the largest block the cache can hold.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (default
    // first), otherwise synthesis infers a latch to hold the old value.
    clamped_len = BEAT_W'(cache_mem_burst_len);
    if (int'(cache_mem_burst_len) > MAX_LEN) begin
      clamped_len = BEAT_W'(MAX_LEN);
    end
  end

  // Drive the shared memory address from the active transaction.
  always_comb begin
    mem_addr = '0;
    case (state)
      BURST:   mem_addr = base + (ADDR_WIDTH'(beat) << 2);
      DATA:    mem_addr = data_addr;
      default: mem_addr = '0;
    endcase
  end

  // Arbitration FSM plus the registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset along with the control state,
      // because every output must read 0 after reset; a plain storage array
      // would normally be left unreset.
      state            <= IDLE;
      beat             <= '0;
      len              <= '0;
      base             <= '0;
      data_addr        <= '0;
      last_grant_cache <= 1'b0;
      cache_mem_ready  <= 1'b0;
      cache_mem_data   <= '0;
      cache_mem_valid  <= 1'b0;
      cache_mem_last   <= 1'b0;
      dport_rdata      <= '0;
      dport_ack        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge value of every other one regardless of order.
      cache_mem_ready <= 1'b0;
      cache_mem_valid <= 1'b0;
      cache_mem_last  <= 1'b0;
      dport_ack       <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_cache) begin
            state            <= BURST;
            base             <= cache_mem_addr & WORD_MASK;
            len              <= clamped_len;
            beat             <= '0;
            last_grant_cache <= 1'b1;
            cache_mem_ready  <= 1'b1;
          end else if (eff_data) begin
            state            <= DATA;
            data_addr        <= dport_addr & WORD_MASK;
            last_grant_cache <= 1'b0;
          end
        end

        BURST: begin
          cache_mem_data  <= mem_data;
          cache_mem_valid <= 1'b1;
          cache_mem_last  <= (beat == len);
          if (beat == len) begin
            state <= IDLE;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end

        DATA: begin
          dport_rdata <= mem_data;
          dport_ack   <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed scenarios followed by randomized traffic.
// A transaction-level schedule (what each output must show in every cycle)
// is built from the arbitration rules and compared against the DUT.
module tb_imem_port_arbiter;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BLOCK_SIZE = 8;
  localparam int NC         = 2400;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cache_mem_req;
  logic [ADDR_WIDTH-1:0] cache_mem_addr;
  logic [3:0]            cache_mem_burst_len;
  logic                  cache_mem_ready;
  logic [DATA_WIDTH-1:0] cache_mem_data;
  logic                  cache_mem_valid;
  logic                  cache_mem_last;
  logic                  dport_req;
  logic [ADDR_WIDTH-1:0] dport_addr;
  logic [DATA_WIDTH-1:0] dport_rdata;
  logic                  dport_ack;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  grant_cache;
  logic                  grant_data;

  imem_port_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .BLOCK_SIZE(BLOCK_SIZE)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cache_mem_req      (cache_mem_req),
    .cache_mem_addr     (cache_mem_addr),
    .cache_mem_burst_len(cache_mem_burst_len),
    .cache_mem_ready    (cache_mem_ready),
    .cache_mem_data     (cache_mem_data),
    .cache_mem_valid    (cache_mem_valid),
    .cache_mem_last     (cache_mem_last),
    .dport_req          (dport_req),
    .dport_addr         (dport_addr),
    .dport_rdata        (dport_rdata),
    .dport_ack          (dport_ack),
    .mem_addr           (mem_addr),
    .mem_data           (mem_data),
    .grant_cache        (grant_cache),
    .grant_data         (grant_data)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed marker at 0x40, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  always_comb mem_data = mem_word(mem_addr);

  // Expected per-cycle schedule.
  bit        exp_ready [NC];
  bit        exp_valid [NC];
  bit        exp_last  [NC];
  bit        exp_ack   [NC];
  bit        exp_gc    [NC];
  bit        exp_gd    [NC];
  bit        exp_zero  [NC];
  bit [31:0] exp_cdata [NC];
  bit [31:0] exp_rdata [NC];
  bit [31:0] exp_maddr [NC];

  int        cyc;
  int        free_at;
  bit        lg_cache;
  bit        chk_en;
  int        checks;
  int        errors;
  bit [31:0] cur_cd;
  bit [31:0] cur_rd;

  // Requester state.
  bit          c_pending;
  bit          d_pending;
  logic [31:0] c_addr;
  logic [3:0]  c_len;
  logic [31:0] d_addr;
  bit          rand_en;

  // Observation logs for the scenario-level checks.
  int          vcnt;
  bit [31:0]   alog[$];
  bit [31:0]   rlog[$];
  int          glog[$];
  logic        prev_gc;
  logic        prev_gd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input int c);
    if (exp_zero[c]) begin
      cur_cd = '0;
      cur_rd = '0;
    end
    if (exp_valid[c]) cur_cd = exp_cdata[c];
    if (exp_ack[c])   cur_rd = exp_rdata[c];
    check("ready",       cache_mem_ready, exp_ready[c]);
    check("valid",       cache_mem_valid, exp_valid[c]);
    check("last",        cache_mem_last,  exp_last[c]);
    check("cache_data",  cache_mem_data,  cur_cd);
    check("ack",         dport_ack,       exp_ack[c]);
    check("rdata",       dport_rdata,     cur_rd);
    check("mem_addr",    mem_addr,        exp_maddr[c]);
    check("grant_cache", grant_cache,     exp_gc[c]);
    check("grant_data",  grant_data,      exp_gd[c]);
  endtask

  // Schedule the consequences of the inputs seen in cycle c.
  task automatic model_update(input int c);
    int        n;
    bit [31:0] a;
    bit        eff_c;
    bit        eff_d;
    if (rst) begin
      for (int i = c + 1; i < NC; i++) begin
        exp_ready[i] = 0; exp_valid[i] = 0; exp_last[i] = 0; exp_ack[i] = 0;
        exp_gc[i] = 0; exp_gd[i] = 0; exp_zero[i] = 0;
        exp_cdata[i] = '0; exp_rdata[i] = '0; exp_maddr[i] = '0;
      end
      exp_zero[c+1] = 1;
      free_at       = c + 1;
      lg_cache      = 0;
    end else if (c >= free_at) begin
      eff_c = cache_mem_req && !exp_ready[c];
      eff_d = dport_req && !exp_ack[c];
      if (eff_c && (!eff_d || !lg_cache)) begin
        n = (int'(cache_mem_burst_len) > BLOCK_SIZE - 1) ? BLOCK_SIZE
                                                         : int'(cache_mem_burst_len) + 1;
        exp_ready[c+1] = 1;
        for (int k = 0; k < n; k++) begin
          a = (cache_mem_addr & ~32'h3) + 32'(4 * k);
          exp_maddr[c+1+k] = a;
          exp_gc[c+1+k]    = 1;
          exp_valid[c+2+k] = 1;
          exp_cdata[c+2+k] = mem_word(a);
        end
        exp_last[c+1+n] = 1;
        free_at         = c + 1 + n;
        lg_cache        = 1;
      end else if (eff_d) begin
        a              = dport_addr & ~32'h3;
        exp_gd[c+1]    = 1;
        exp_maddr[c+1] = a;
        exp_ack[c+2]   = 1;
        exp_rdata[c+2] = mem_word(a);
        free_at        = c + 2;
        lg_cache       = 0;
      end
    end
  endtask

  task automatic log_observe();
    if (cache_mem_valid === 1'b1) vcnt++;
    if (grant_cache === 1'b1) alog.push_back(mem_addr);
    if (dport_ack === 1'b1) rlog.push_back(dport_rdata);
    if (grant_cache === 1'b1 && prev_gc !== 1'b1) glog.push_back(1);
    if (grant_data === 1'b1 && prev_gd !== 1'b1) glog.push_back(2);
    prev_gc = grant_cache;
    prev_gd = grant_data;
  endtask

  task automatic drive_cycle();
    if (rand_en) begin
      if (!c_pending && $urandom_range(0, 2) == 0) begin
        c_pending = 1;
        c_addr    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63)))
                                                 : 32'($urandom);
        c_len     = 4'($urandom_range(0, 15));
      end
      if (!d_pending && $urandom_range(0, 2) == 0) begin
        d_pending = 1;
        d_addr    = ($urandom_range(0, 4) == 0) ? 32'h0000_0040 : 32'($urandom);
      end
      rst = ($urandom_range(0, 149) == 0);
    end
    cache_mem_req       = c_pending;
    cache_mem_addr      = c_addr;
    cache_mem_burst_len = c_len;
    dport_req           = d_pending;
    dport_addr          = d_addr;
  endtask

  task automatic step();
    @(negedge clk);
    chk_en = (cyc >= 1);
    if (chk_en) check_outputs(cyc);
    log_observe();
    model_update(cyc);
    if (rst) begin
      c_pending = 0;
      d_pending = 0;
    end
    if (exp_ready[cyc]) c_pending = 0;
    if (exp_ack[cyc])   d_pending = 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive_cycle();
      step();
    end
  endtask

  task automatic post_cache(input logic [31:0] addr, input logic [3:0] len);
    c_pending = 1;
    c_addr    = addr;
    c_len     = len;
  endtask

  task automatic post_data(input logic [31:0] addr);
    d_pending = 1;
    d_addr    = addr;
  endtask

  initial begin
    rst       = 1'b1;
    c_pending = 0;
    d_pending = 0;
    c_addr    = '0;
    c_len     = '0;
    d_addr    = '0;
    rand_en   = 0;
    cyc       = 0;
    free_at   = 0;
    lg_cache  = 0;
    checks    = 0;
    errors    = 0;
    vcnt      = 0;
    prev_gc   = 1'b0;
    prev_gd   = 1'b0;
    drive_cycle();
    @(posedge clk);
    #1;

    // Reset, then contention straight out of reset: cache, data, cache.
    run(2);
    rst = 1'b0;
    check("reset_mem_addr",  mem_addr, 32'h0);
    check("reset_ack",       dport_ack, 1'b0);
    glog.delete();
    post_cache(32'h0000_0200, 4'd1);
    post_data(32'h0000_0044);
    run(2);
    post_cache(32'h0000_0600, 4'd0);
    run(20);
    check("contention_grants", glog.size(), 3);
    for (int i = 0; i < glog.size() && i < 3; i++) begin
      check("contention_order", glog[i], (i == 1) ? 2 : 1);
    end

    // Refill with unaligned address and eight beats.
    alog.delete();
    vcnt = 0;
    post_cache(32'h0000_0103, 4'd7);
    run(14);
    check("refill_beats", vcnt, 8);
    check("refill_addrs", alog.size(), 8);
    for (int k = 0; k < alog.size() && k < 8; k++) begin
      check("refill_addr", alog[k], 32'h0000_0100 + 32'(4 * k));
    end

    // Burst length clamped to the block size.
    vcnt = 0;
    post_cache(32'h0000_1000, 4'd15);
    run(14);
    check("clamp_beats", vcnt, 8);

    // Single data read, request held through the ack cycle.
    rlog.delete();
    post_data(32'h0000_0040);
    run(6);
    check("dread_acks", rlog.size(), 1);
    if (rlog.size() > 0) check("dread_rdata", rlog[0], 32'hDEAD_BEEF);

    // Address wrap at the top of the address space.
    alog.delete();
    post_cache(32'hFFFF_FFF8, 4'd3);
    run(8);
    check("wrap_addrs", alog.size(), 4);
    for (int k = 0; k < alog.size() && k < 4; k++) begin
      check("wrap_addr", alog[k], (k == 0) ? 32'hFFFF_FFF8 : (k == 1) ? 32'hFFFF_FFFC
                                 : (k == 2) ? 32'h0000_0000 : 32'h0000_0004);
    end

    // Reset on the third beat of a burst, then a fresh request.
    vcnt = 0;
    post_cache(32'h0000_0300, 4'd7);
    run(4);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("abort_beats_before_reset", vcnt, 3);
    vcnt = 0;
    run(10);
    check("abort_no_beats", vcnt, 0);
    post_cache(32'h0000_0500, 4'd2);
    run(8);
    check("after_reset_beats", vcnt, 3);

    // Randomized traffic with occasional resets.
    rand_en = 1;
    run(2000);
    rand_en = 0;
    rst     = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: data width.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 8: maximum number of burst beats (words).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port cache_mem_req, input, 1 bit: I-cache refill request.
REQ-007 The block SHALL have port cache_mem_addr, input, ADDR_WIDTH: refill start byte address.
REQ-008 The block SHALL have port cache_mem_burst_len, input, 4 bits: beats minus one.
REQ-009 The block SHALL have port cache_mem_ready, output, 1 bit: one-cycle pulse when the burst is accepted.
REQ-010 The block SHALL have port cache_mem_data, output, DATA_WIDTH: refill beat data.
REQ-011 The block SHALL have port cache_mem_valid, output, 1 bit: cache_mem_data is valid this cycle.
REQ-012 The block SHALL have port cache_mem_last, output, 1 bit: final beat, coincident with valid.
REQ-013 The block SHALL have port dport_req, input, 1 bit: CPU data-side read of the instruction region, held high until dport_ack.
REQ-014 The block SHALL have port dport_addr, input, ADDR_WIDTH: data-side read byte address.
REQ-015 The block SHALL have port dport_rdata, output, DATA_WIDTH: data-side read word.
REQ-016 The block SHALL have port dport_ack, output, 1 bit: one-cycle pulse; dport_rdata is valid.
REQ-017 The block SHALL have port mem_addr, output, ADDR_WIDTH: address to the single combinational instruction-memory port.
REQ-018 The block SHALL have port mem_data, input, DATA_WIDTH: memory word, valid in the same cycle as mem_addr.
REQ-019 The block SHALL have port grant_cache, output, 1 bit: high in BURST state (debug).
REQ-020 The block SHALL have port grant_data, output, 1 bit: high in DATA state (debug).

Function
REQ-021 The FSM SHALL have states IDLE, BURST and DATA, and requests SHALL be sampled only in IDLE.
REQ-022 IDLE SHALL behave as follows: a single effective request goes to its state; when both requests are effective, the grant goes to the requester not granted last (last_grant register); neither leaves the FSM in IDLE.
REQ-023 The effective dport request SHALL be dport_req and not dport_ack (masks the ack cycle).
REQ-024 The effective cache request SHALL be cache_mem_req and not cache_mem_ready.
REQ-025 On the IDLE to BURST transition, the block SHALL latch base = {cache_mem_addr[ADDR_WIDTH-1:2], 2'b00} and len = min(cache_mem_burst_len, BLOCK_SIZE-1), clear beat, set last_grant = cache, and drive cache_mem_ready high in the next cycle only.
REQ-026 In BURST, mem_addr SHALL equal base + 4*beat (modulo 2^ADDR_WIDTH, no block wrap); at each edge, mem_data is registered into cache_mem_data, cache_mem_valid is set to 1, and cache_mem_last is set to (beat == len).
REQ-027 When beat == len in BURST, the FSM SHALL return to IDLE; otherwise beat SHALL increment.
REQ-028 A burst of len+1 beats accepted in cycle t SHALL produce valid data in cycles t+2 through t+len+2, with last in cycle t+len+2; the block SHALL be in IDLE in cycle t+len+2.
REQ-029 The cache requester SHALL deassert cache_mem_req by the cycle after cache_mem_ready; cache_mem_req SHALL be ignored outside IDLE.
REQ-030 On the IDLE to DATA transition, the block SHALL latch the word-aligned dport_addr and set last_grant = data.
REQ-031 In DATA, mem_addr SHALL equal the latched address; at the edge, dport_rdata is set to mem_data, dport_ack is set to 1, and the FSM returns to IDLE; a request sampled in cycle t SHALL be acked in cycle t+2.
REQ-032 In IDLE, mem_addr SHALL be 0.
REQ-033 cache_mem_valid, cache_mem_last, cache_mem_ready and dport_ack SHALL be single-cycle pulses, and the data outputs SHALL hold their last value otherwise.
REQ-034 A dport_req arriving during a burst SHALL wait at most len+2 cycles before grant.
REQ-035 Under continuous contention, grants SHALL alternate strictly.

Reset
REQ-036 With rst high at an edge, the block SHALL set state to IDLE, beat to 0, and last_grant to data (the cache wins the first tie).
REQ-037 With rst high at an edge, all outputs SHALL be 0.
REQ-038 Reset mid-burst or mid-DATA SHALL abort the transaction with no further valid, last or ack pulses.

Verification
REQ-039 Refill scenario: cache_mem_req with addr 0x0000_0103 and len 7 in cycle t produces ready at t+1, mem_addr 0x100..0x11C over t+1..t+8, valid at t+2..t+9, and last only at t+9.
REQ-040 Data read scenario: dport_req with addr 0x40, where mem holds 0xDEADBEEF, produces grant_data at t+1, dport_ack with rdata 0xDEADBEEF at t+2, and no second ack while req is held through t+2.
REQ-041 Contention scenario: both requests asserted out of reset produce cache granted first, then data granted in the cycle after last, then cache granted again on the next tie.
REQ-042 Clamp scenario: burst_len 15 with BLOCK_SIZE 8 produces exactly 8 valid beats.
REQ-043 Address wrap scenario: addr 0xFFFF_FFF8 with len 3 produces mem_addr sequence FFF8, FFFC, 0000, 0004.
REQ-044 Reset scenario: rst asserted at the 3rd beat of a burst produces all outputs at 0 the next cycle, state IDLE, and a fresh request completing normally afterward.
